// File: rtl/board_input_conditioner_pkg.sv
// Shared constants for the board switch/key conditioning path.
// The system top reuses these so the Avalon inport width and key polarity stay in one place.
package board_input_conditioner_pkg;

    localparam int IN_WIDTH = 16;

    // Keys on [15:12] are active-low on the board; switches are active-high.
    localparam logic [IN_WIDTH-1:0] DEFAULT_INVERT_MASK = 16'hF000;

endpackage

// File: rtl/board_input_conditioner_debounce_bit.sv
// One debounced input bit: persistence counter, accepted level and edge pulses.
// Advances only on the shared sample tick from the parent.
module input_debounce_bit #(
    parameter int DB_TICKS = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_tick,
    input  logic i_sample,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = $clog2(DB_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    logic [CW-1:0] r_count;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;

    // A matching sample wipes any partial count, so short glitches never accumulate.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (i_sample == r_level) begin
                r_count <= '0;
            end else if (i_tick) begin
                if (r_count == CNT_LAST) begin
                    r_count <= '0;
                    r_level <= ~r_level;
                    r_rise  <= ~r_level;
                    r_fall  <= r_level;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/board_input_conditioner.sv
// Board switch/key conditioner: synchronise, polarity-correct, debounce and flag edges.
// Feeds the PCIe application-domain inport and its edge-event interrupt flag.
module board_input_conditioner
    import board_input_conditioner_pkg::*;
#(
    parameter int                  TICK_DIV    = 50000,
    parameter int                  DB_TICKS    = 10,
    parameter logic [IN_WIDTH-1:0] INVERT_MASK = DEFAULT_INVERT_MASK
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [IN_WIDTH-1:0] raw_in,
    output logic [IN_WIDTH-1:0] db_out,
    output logic [IN_WIDTH-1:0] rise_pulse,
    output logic [IN_WIDTH-1:0] fall_pulse,
    output logic                evt_pending,
    input  logic                evt_clr
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [IN_WIDTH-1:0] r_sync1;
    logic [IN_WIDTH-1:0] r_sync2;
    logic [PW-1:0]       r_presc;
    logic                r_evtPending;
    logic [IN_WIDTH-1:0] w_sample;
    logic                w_tick;
    logic                w_anyEdge;

    // Sync flops reset to the inversion mask so idle keys read as released.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= INVERT_MASK;
            r_sync2 <= INVERT_MASK;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2 ^ INVERT_MASK;
    assign w_tick   = (r_presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar i = 0; i < IN_WIDTH; i++) begin : g_bit
        input_debounce_bit #(
            .DB_TICKS (DB_TICKS)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_tick   (w_tick),
            .i_sample (w_sample[i]),
            .o_level  (db_out[i]),
            .o_rise   (rise_pulse[i]),
            .o_fall   (fall_pulse[i])
        );
    end

    assign w_anyEdge = (|rise_pulse) | (|fall_pulse);

    // A new edge wins over a coincident clear so no event is ever lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_evtPending <= 1'b0;
        end else if (w_anyEdge) begin
            r_evtPending <= 1'b1;
        end else if (evt_clr) begin
            r_evtPending <= 1'b0;
        end
    end

    assign evt_pending = r_evtPending;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed scoreboard bench for board_input_conditioner with a fast tick (4) and short debounce (3).
module tb_board_input_conditioner;
    import board_input_conditioner_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int DB_TICKS = 3;
    localparam int LAT_MIN  = 2 + (DB_TICKS - 1) * TICK_DIV + 1;
    localparam int LAT_MAX  = 2 + DB_TICKS * TICK_DIV;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] raw_in;
    logic [15:0] db_out;
    logic [15:0] rise_pulse;
    logic [15:0] fall_pulse;
    logic        evt_pending;
    logic        evt_clr;

    typedef struct {
        logic [15:0] mask;
        logic        isRise;
        logic [15:0] expDb;
        int          startCycle;
    } expEvent_t;

    expEvent_t expQ[$];
    int cycleCount = 0;
    int checks = 0;
    int errors = 0;

    board_input_conditioner #(
        .TICK_DIV    (TICK_DIV),
        .DB_TICKS    (DB_TICKS),
        .INVERT_MASK (16'hF000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .raw_in      (raw_in),
        .db_out      (db_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .evt_pending (evt_pending),
        .evt_clr     (evt_clr)
    );

    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        #1;
        cycleCount++;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive raw_in and record the edge event it must eventually cause.
    task automatic applyStimulus(input logic [15:0] raw, input logic [15:0] mask,
                                 input logic isRise, input logic [15:0] expDb);
        expEvent_t e;
        raw_in = raw;
        e.mask = mask;
        e.isRise = isRise;
        e.expDb = expDb;
        e.startCycle = cycleCount;
        expQ.push_back(e);
    endtask

    task automatic checkQuiet(input string tag, input int n, input logic [15:0] expDb, input logic expEvt);
        for (int k = 0; k < n; k++) begin
            stepCycle();
            checkOutput({tag, "_db"}, db_out, expDb);
            checkOutput({tag, "_rise"}, rise_pulse, 16'h0000);
            checkOutput({tag, "_fall"}, fall_pulse, 16'h0000);
            checkOutput({tag, "_evt"}, {15'd0, evt_pending}, {15'd0, expEvt});
        end
    endtask

    task automatic waitEvent(input string tag, input logic clrOnPulse);
        expEvent_t e;
        logic seen;
        int lat;
        seen = 1'b0;
        e = expQ.pop_front();
        for (int n = 0; n < LAT_MAX + 6 && !seen; n++) begin
            stepCycle();
            if ((rise_pulse | fall_pulse) != 16'h0000) seen = 1'b1;
        end
        lat = cycleCount - e.startCycle;
        checkOutput({tag, "_seen"}, {15'd0, seen}, 16'd1);
        if (seen) begin
            checkOutput({tag, "_latInRange"}, {15'd0, (lat >= LAT_MIN && lat <= LAT_MAX)}, 16'd1);
            checkOutput({tag, "_rise"}, rise_pulse, e.isRise ? e.mask : 16'h0000);
            checkOutput({tag, "_fall"}, fall_pulse, e.isRise ? 16'h0000 : e.mask);
            checkOutput({tag, "_db"}, db_out, e.expDb);
            evt_clr = clrOnPulse;
            stepCycle();
            checkOutput({tag, "_evtSet"}, {15'd0, evt_pending}, 16'd1);
            checkOutput({tag, "_riseOneCycle"}, rise_pulse, 16'h0000);
            checkOutput({tag, "_fallOneCycle"}, fall_pulse, 16'h0000);
            checkOutput({tag, "_dbHeld"}, db_out, e.expDb);
            if (clrOnPulse) begin
                stepCycle();
                evt_clr = 1'b0;
                checkOutput({tag, "_evtClrAlone"}, {15'd0, evt_pending}, 16'd0);
            end
        end
    endtask

    task automatic clearEvt(input string tag);
        evt_clr = 1'b1;
        stepCycle();
        evt_clr = 1'b0;
        checkOutput({tag, "_evtCleared"}, {15'd0, evt_pending}, 16'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        raw_in  = 16'hF000;
        evt_clr = 1'b0;

        // Reset with all inputs idle, then 50 quiet cycles.
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("rst_db", db_out, 16'h0000);
        checkOutput("rst_rise", rise_pulse, 16'h0000);
        checkOutput("rst_fall", fall_pulse, 16'h0000);
        checkOutput("rst_evt", {15'd0, evt_pending}, 16'd0);
        reset_n = 1'b1;
        checkQuiet("idle", 50, 16'h0000, 1'b0);

        // Switch 0 goes high and stays.
        applyStimulus(16'hF001, 16'h0001, 1'b1, 16'h0001);
        waitEvent("rise0", 1'b0);
        clearEvt("rise0");

        // Short glitch on switch 5 must be filtered out.
        raw_in = 16'hF021;
        checkQuiet("glitch5hi", 5, 16'h0001, 1'b0);
        raw_in = 16'hF001;
        checkQuiet("glitch5lo", 40, 16'h0001, 1'b0);

        // Active-low key 15: press then release.
        applyStimulus(16'h7001, 16'h8000, 1'b1, 16'h8001);
        waitEvent("press15", 1'b0);
        clearEvt("press15");
        applyStimulus(16'hF001, 16'h8000, 1'b0, 16'h0001);
        waitEvent("release15", 1'b0);
        clearEvt("release15");

        // Clear request coinciding with a fresh edge must not drop the event.
        applyStimulus(16'hF009, 16'h0008, 1'b1, 16'h0009);
        waitEvent("rise3", 1'b0);
        checkOutput("evtHeldBeforeFall3", {15'd0, evt_pending}, 16'd1);
        applyStimulus(16'hF001, 16'h0008, 1'b0, 16'h0001);
        waitEvent("fall3", 1'b1);

        // Reset mid-count on switch 7; bit 0 re-accepts alongside it after release.
        raw_in = 16'hF081;
        checkQuiet("pre_rst7", 8, 16'h0001, 1'b0);
        reset_n = 1'b0;
        checkQuiet("in_rst7", 2, 16'h0000, 1'b0);
        reset_n = 1'b1;
        applyStimulus(16'hF081, 16'h0081, 1'b1, 16'h0081);
        waitEvent("post_rst7", 1'b0);

        checkOutput("queueEmpty", 16'(expQ.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
